// File: rtl/router_out_arbiter_pkg.sv
// Shared types and helpers for the router output-port arbiter and its round-robin picker.
package router_out_arbiter_pkg;

    typedef enum logic [1:0] {
        HEAD      = 2'd0,
        BODY      = 2'd1,
        TAIL      = 2'd2,
        HEAD_TAIL = 2'd3
    } flit_type_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned N_PORTS_DEF = 5;

    function automatic logic is_head(input logic [1:0] ftype);
        return (ftype == HEAD) || (ftype == HEAD_TAIL);
    endfunction

    function automatic logic is_tail(input logic [1:0] ftype);
        return (ftype == TAIL) || (ftype == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned N     = 5,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Upper segment [ptr, N-1] first, then the wrapped segment [0, ptr-1].
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= 32'(ptr))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && req[i] && (i < 32'(ptr))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Wormhole output-port arbiter: round-robin grant on head flits, locked until the tail transfers.
// Optional stall timeout with force-release is enabled by defining ROUTER_ARB_TIMEOUT_EN.
module router_out_arbiter
    import router_out_arbiter_pkg::*;
#(
    parameter int unsigned N_PORTS     = N_PORTS_DEF,
    parameter int unsigned PORT_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [N_PORTS-1:0]     req_valid_i,
    input  logic [2*N_PORTS-1:0]   req_ftype_i,
    input  logic                   out_ready_i,
    output logic [N_PORTS-1:0]     grant_o,
    output logic [PORT_W-1:0]      sel_o,
    output logic                   locked_o,
    output logic                   xfer_o,
    output logic                   timeout_o
);

    arb_state_t          state_q, state_d;
    logic [PORT_W-1:0]   owner_q, owner_d;
    logic [PORT_W-1:0]   ptr_q, ptr_d;
    logic [N_PORTS-1:0]  grant_q, grant_d;

    logic [N_PORTS-1:0]  eligible;
    logic [N_PORTS-1:0]  win_gnt;
    logic [PORT_W-1:0]   win_idx;
    logic                win_any;
    logic                owner_valid;
    logic [1:0]          owner_ftype;
    logic                xfer;
    logic                timeout_hit;
    logic [PORT_W-1:0]   owner_next;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            eligible[i] = req_valid_i[i] && is_head(req_ftype_i[2*i +: 2]);
        end
    end

    rr_arbiter #(
        .N     (N_PORTS),
        .IDX_W (PORT_W)
    ) u_rr (
        .req (eligible),
        .ptr (ptr_q),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign owner_valid = req_valid_i[owner_q];
    assign owner_ftype = req_ftype_i[{owner_q, 1'b0} +: 2];
    assign xfer        = (state_q == ARB_LOCKED) && owner_valid && out_ready_i;
    assign owner_next  = (owner_q == PORT_W'(N_PORTS - 1)) ? '0 : owner_q + PORT_W'(1);

`ifdef ROUTER_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign timeout_hit = (state_q == ARB_LOCKED) && !xfer &&
                         (stall_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Counts consecutive stalled locked cycles; any transfer or release restarts it.
    always_comb begin
        stall_cnt_d = '0;
        if ((state_q == ARB_LOCKED) && !xfer && !timeout_hit) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (win_any) begin
                    state_d = ARB_LOCKED;
                    owner_d = win_idx;
                    grant_d = win_gnt;
                end
            end
            ARB_LOCKED: begin
                if ((xfer && is_tail(owner_ftype)) || timeout_hit) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_next;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign grant_o   = grant_q;
    assign sel_o     = owner_q;
    assign locked_o  = (state_q == ARB_LOCKED);
    assign xfer_o    = xfer;
    assign timeout_o = timeout_hit;

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Wormhole output-port arbiter for one router output port.
- Shares the port between N_PORTS input datapaths. Each input datapath presents one selected VC flit (valid + flit type) toward this port.
- Grant is round-robin among requesters presenting a head flit. It stays locked to the winner until its tail flit transfers.
- Drives the select for the external output crossbar mux and per-port grants that gate each input datapath's ready.

Parameters:
- N_PORTS, 5, number of requesting input ports (N/S/E/W/local).
- PORT_W, $clog2(N_PORTS) (min 1), owner index width.
- TIMEOUT_CYC, 1024, stall limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- arst  in  1  reset; synchronous, active-high.
- req_valid_i  in  N_PORTS  flit valid per requester.
- req_ftype_i  in  2*N_PORTS  flit type per requester, packed [2*i+1:2*i]: 0 HEAD, 1 BODY, 2 TAIL, 3 HEAD_TAIL.
- out_ready_i  in  1  downstream can accept a flit this cycle.
- grant_o  out  N_PORTS  one-hot grant to current owner; all zero when idle.
- sel_o  out  PORT_W  owner index for the crossbar mux.
- locked_o  out  1  arbiter currently owns a packet.
- xfer_o  out  1  flit transfer this cycle: owner's req_valid_i & out_ready_i while locked.
- timeout_o  out  1  one-cycle stall pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (arst=1 at clk edge):
  - state = IDLE; grant_o = 0; sel_o = 0; locked_o = 0; rr pointer = 0; timeout counter = 0.
  - Takes effect mid-packet; the packet is abandoned, with no drain.
- Eligibility:
  - In IDLE, requester i is eligible iff req_valid_i[i] and its ftype is HEAD or HEAD_TAIL.
  - BODY/TAIL flits presented in IDLE are ignored.
- FSM, two states:
  - IDLE: if any requester is eligible, pick the first eligible index searching from rr pointer upward with wrap (ptr, ptr+1, ..., N_PORTS-1, 0, ...). Register owner. Next cycle: LOCKED, grant_o[owner] = 1, sel_o = owner, locked_o = 1. Latency from eligible head to grant = 1 cycle.
  - LOCKED, xfer_o = 1 with owner ftype TAIL or HEAD_TAIL: next cycle IDLE, grant_o = 0, rr pointer = owner+1 (wrap to 0 at N_PORTS).
  - LOCKED, otherwise: remain LOCKED.
    - Owner valid low or out_ready_i low: hold the lock, no transfer.
    - Flit type is examined only for tail detection. HEAD/BODY from the owner counts as a non-tail transfer.
- Bubble: there is always at least one IDLE cycle between packets. A release and a new grant never coincide.
- Outputs grant_o/sel_o/locked_o are registered. xfer_o is combinational from registered grant and the inputs.
- Non-owner requests while LOCKED are never granted and never affect state.
- All requesters eligible at once: strict round-robin. The N_PORTS consecutive single-flit packets are granted in ptr order, each port once.

Optional Feature:
- Macro ROUTER_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each LOCKED cycle without xfer_o and clears on xfer_o or on leaving LOCKED.
  - On reaching TIMEOUT_CYC-1, timeout_o pulses 1 cycle and the arbiter force-releases to IDLE, advancing rr pointer past the owner.
- Not defined: no counter; timeout_o = 0; a lock persists indefinitely.

Decomposition:
- ravenoc_pkg additions:
  - typedef enum logic [1:0] flit_type_t {HEAD, BODY, TAIL, HEAD_TAIL}.
  - typedef enum logic arb_state_t {ARB_IDLE, ARB_LOCKED}.
  - Constant N_PORTS default.
- Sub-module rr_arbiter (combinational): request vector plus pointer in, one-hot winner and index out. Reusable for VC allocation.

Test Plan (N_PORTS=4, TIMEOUT_CYC=8):
1. Reset then idle:
   - Stimulus: all req_valid_i = 0 for 5 cycles.
   - Required: grant_o = 0, locked_o = 0, sel_o = 0, xfer_o = 0 throughout.
2. Single packet:
   - Stimulus: port 2 sends HEAD, BODY, TAIL with out_ready_i = 1.
   - Required: grant_o = 4'b0100 one cycle after HEAD valid; xfer_o high 3 cycles; grant_o = 0 the cycle after TAIL; pointer = 3.
3. Round-robin fairness:
   - Stimulus: ports 0–3 all hold HEAD_TAIL continuously from reset.
   - Required: grant order 0, 1, 2, 3, 0, with one idle cycle between grants.
4. Backpressure and lock hold:
   - Stimulus: port 1 HEAD transfers, then out_ready_i = 0 for 4 cycles while port 3 presents HEAD.
   - Required: grant stays 4'b0010, xfer_o = 0; port 3 granted only after port 1's TAIL transfers.
5. Ignored non-head and reset mid-packet:
   - Stimulus: port 0 presents BODY in IDLE; then port 2 locks and arst = 1 mid-packet.
   - Required: no grant for port 0; after reset, grant_o = 0 and pointer = 0.
6. Timeout (ROUTER_ARB_TIMEOUT_EN defined):
   - Stimulus: port 3 locks, then its valid is held low.
   - Required: timeout_o pulses on stall cycle 8; IDLE next cycle; next winner searched from port 0.
